// File: rtl/bist_ctrl_if.sv
// Handshake and result bundle between a BIST controller and its test driver.
// The pass signal exists only when BIST_CMP_EN is defined.
interface bist_ctrl_if;
  logic        start;
  logic        y_in;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic [15:0] signature;
`ifdef BIST_CMP_EN
  logic        pass;

  modport master (
    output start, y_in,
    input  a, b, c, d, busy, done, signature, pass
  );

  modport slave (
    input  start, y_in,
    output a, b, c, d, busy, done, signature, pass
  );
`else
  modport master (
    output start, y_in,
    input  a, b, c, d, busy, done, signature
  );

  modport slave (
    input  start, y_in,
    output a, b, c, d, busy, done, signature
  );
`endif
endinterface

// File: rtl/bist_ctrl.sv
// LFSR pattern generator + SISR response compactor with IDLE/FLUSH/RUN/DONE sequencing.
// Optional golden-signature comparator and pass output are built only under BIST_CMP_EN.
module bist_ctrl #(
  parameter int unsigned NUM_PATTERNS = 15,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [3:0]  SEED         = 4'b0001
`ifdef BIST_CMP_EN
  ,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
`endif
) (
  input logic        clk,
  input logic        rst,
  bist_ctrl_if.slave bus
);

  localparam int unsigned PAT_W = 4;
  localparam int unsigned SIG_W = 16;
  localparam int unsigned FC_W  = 4;
  localparam int unsigned PC_W  = 8;

  localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [PC_W-1:0]  PAT_LAST   = PC_W'(NUM_PATTERNS - 1);
  localparam logic [SIG_W-1:0] SISR_POLY  = 16'h1021;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [FC_W-1:0]  flush_cnt;
  logic [PC_W-1:0]  pat_cnt;
  logic [PAT_W-1:0] lfsr;
  logic [SIG_W-1:0] sig;
  logic [PAT_W-1:0] pat;
  logic             busy_q;
  logic             done_q;
`ifdef BIST_CMP_EN
  logic             pass_q;
`endif

  logic [PAT_W-1:0] lfsr_nxt;
  logic [SIG_W-1:0] sig_nxt;
  logic             fb;

  // Next LFSR value and next SISR value with the current response folded in
  always_comb begin
    lfsr_nxt = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    fb       = sig[SIG_W-1] ^ bus.y_in;
    sig_nxt  = {sig[SIG_W-2:0], 1'b0} ^ (fb ? SISR_POLY : '0);
  end

  // Sequencer; every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      pat_cnt   <= '0;
      lfsr      <= SEED;
      sig       <= '0;
      pat       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BIST_CMP_EN
      pass_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            pat_cnt   <= '0;
            lfsr      <= SEED;
            sig       <= '0;
            pat       <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
`ifdef BIST_CMP_EN
            pass_q    <= 1'b0;
`endif
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state <= RUN;
            pat   <= lfsr;
          end else begin
            flush_cnt <= flush_cnt + FC_W'(1);
          end
        end
        RUN: begin
          sig  <= sig_nxt;
          lfsr <= lfsr_nxt;
          if (pat_cnt == PAT_LAST) begin
            state  <= DONE;
            pat    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
`ifdef BIST_CMP_EN
            // Compare against the signature that DONE will hold
            pass_q <= (sig_nxt == GOLDEN_SIG);
`endif
          end else begin
            pat_cnt <= pat_cnt + PC_W'(1);
            pat     <= lfsr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a         = pat[3];
  assign bus.b         = pat[2];
  assign bus.c         = pat[1];
  assign bus.d         = pat[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = sig;
`ifdef BIST_CMP_EN
  assign bus.pass      = pass_q;
`endif

endmodule
